// File: rtl/vector_reg_file_lanes.sv
// vector_reg_file_lanes
//   Vector register file of NREGS registers, each LANES lanes of LANE_W bits.
//   Lane i of a register occupies bits [i*LANE_W +: LANE_W] (lane 0 = LSBs).
//   Ports:
//     clk, rst          clock (rising edge) and synchronous active-high reset
//     ra1/ra2, rd1/rd2  two combinational read ports
//     we, wa, wmask, wd full-width write port with per-lane mask
//                       (optionally forwarded to the read ports when BYPASS=1)
//     fill_start/addr   start a lane-serial load into register fill_addr
//     fill_valid/data   one lane per accepted beat (fill_valid & fill_ready)
//     fill_ready        high while the fill engine accepts beats
//     fill_done         one-cycle pulse after the last lane has been written
//     busy              high while a fill is in progress
module vector_reg_file_lanes #(
  parameter int LANES  = 4,
  parameter int LANE_W = 32,
  parameter int NREGS  = 8,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS),
  localparam int VW = LANES * LANE_W,
  localparam int CW = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [VW-1:0]     rd1,
  output logic [VW-1:0]     rd2,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [LANES-1:0]  wmask,
  input  logic [VW-1:0]     wd,
  input  logic              fill_start,
  input  logic [AW-1:0]     fill_addr,
  input  logic              fill_valid,
  input  logic [LANE_W-1:0] fill_data,
  output logic              fill_ready,
  output logic              fill_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     fill_reg_q, fill_reg_d;
  logic              fill_ready_q, fill_ready_d;
  logic              fill_done_q, fill_done_d;
  logic              busy_q, busy_d;

  logic [VW-1:0]     mem_q [NREGS];
  logic [VW-1:0]     mem_d [NREGS];

  logic              fill_beat;

  // fill_ready_q mirrors "state is FILL", so this is an accepted beat.
  assign fill_beat = fill_ready_q && fill_valid;

  // ---------------- Storage update ----------------
  // The port write is applied first and the fill beat second, so a fill beat
  // wins any lane both of them target on the same edge.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) begin
          mem_d[wa][i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
        end
      end
    end
    if (fill_beat) begin
      for (int i = 0; i < LANES; i++) begin
        if (cnt_q == CW'(i)) begin
          mem_d[fill_reg_q][i*LANE_W +: LANE_W] = fill_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // ---------------- Read ports ----------------
  // Only the write port is forwarded; fill beats become visible next cycle.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_rd_lane
    logic byp1, byp2;
    assign byp1 = (BYPASS != 0) && we && (wa == ra1) && wmask[gi];
    assign byp2 = (BYPASS != 0) && we && (wa == ra2) && wmask[gi];
    assign rd1[gi*LANE_W +: LANE_W] = byp1 ? wd[gi*LANE_W +: LANE_W]
                                           : mem_q[ra1][gi*LANE_W +: LANE_W];
    assign rd2[gi*LANE_W +: LANE_W] = byp2 ? wd[gi*LANE_W +: LANE_W]
                                           : mem_q[ra2][gi*LANE_W +: LANE_W];
  end

  // ---------------- Fill FSM ----------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_reg_d = fill_reg_q;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          state_d    = S_FILL;
          cnt_d      = '0;
          fill_reg_d = fill_addr;
        end
      end
      S_FILL: begin
        if (fill_valid) begin
          // Counter holds at LANES-1 on the final beat; it never wraps.
          if (cnt_q == CW'(LANES - 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Outputs are decoded from the next state so they can be registered.
    fill_ready_d = (state_d == S_FILL);
    fill_done_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      fill_reg_q   <= '0;
      fill_ready_q <= 1'b0;
      fill_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_reg_q   <= fill_reg_d;
      fill_ready_q <= fill_ready_d;
      fill_done_q  <= fill_done_d;
      busy_q       <= busy_d;
    end
  end

  assign fill_ready = fill_ready_q;
  assign fill_done  = fill_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_vector_reg_file_lanes.sv
// tb_vector_reg_file_lanes
//   Directed scenarios followed by randomized traffic on the write, read and
//   fill ports, all checked cycle by cycle against a behavioural model.
module tb_vector_reg_file_lanes;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int NREGS  = 8;
  localparam int BYPASS = 1;
  localparam int AW     = $clog2(NREGS);
  localparam int VW     = LANES * LANE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     ra1, ra2;
  logic [VW-1:0]     rd1, rd2;
  logic              we;
  logic [AW-1:0]     wa;
  logic [LANES-1:0]  wmask;
  logic [VW-1:0]     wd;
  logic              fill_start;
  logic [AW-1:0]     fill_addr;
  logic              fill_valid;
  logic [LANE_W-1:0] fill_data;
  logic              fill_ready, fill_done, busy;

  vector_reg_file_lanes #(
    .LANES (LANES),
    .LANE_W(LANE_W),
    .NREGS (NREGS),
    .BYPASS(BYPASS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ra1       (ra1),
    .ra2       (ra2),
    .rd1       (rd1),
    .rd2       (rd2),
    .we        (we),
    .wa        (wa),
    .wmask     (wmask),
    .wd        (wd),
    .fill_start(fill_start),
    .fill_addr (fill_addr),
    .fill_valid(fill_valid),
    .fill_data (fill_data),
    .fill_ready(fill_ready),
    .fill_done (fill_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt;
  int done_cnt;

  // Behavioural model: register contents plus a simple view of the fill job.
  logic [VW-1:0] m_regs [NREGS];
  bit            m_active;   // a fill is accepting beats
  bit            m_done;     // the completion pulse is due this cycle
  int            m_lane;     // next lane the fill will write
  int            m_faddr;    // register being filled

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [VW-1:0] exp_rd(input logic [AW-1:0] ra);
    logic [VW-1:0] r;
    r = m_regs[ra];
    if (BYPASS != 0 && we && wa == ra) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) r[i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
      end
    end
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      m_active = 0;
      m_done   = 0;
      m_lane   = 0;
    end else begin
      if (we) begin
        for (int i = 0; i < LANES; i++) begin
          if (wmask[i]) m_regs[wa][i*LANE_W +: LANE_W] = wd[i*LANE_W +: LANE_W];
        end
      end
      if (m_active && fill_valid) m_regs[m_faddr][m_lane*LANE_W +: LANE_W] = fill_data;
      if (m_done) begin
        m_done = 0;
      end else if (m_active) begin
        if (fill_valid) begin
          if (m_lane == LANES - 1) begin
            m_active = 0;
            m_done   = 1;
          end else begin
            m_lane++;
          end
        end
      end else if (fill_start) begin
        m_active = 1;
        m_lane   = 0;
        m_faddr  = int'(fill_addr);
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven: check the
  // current outputs, advance the model, then move to the next falling edge.
  task automatic cycle();
    #1;
    check("rd1", rd1, exp_rd(ra1));
    check("rd2", rd2, exp_rd(ra2));
    check("fill_ready", VW'(fill_ready), VW'(m_active));
    check("fill_done", VW'(fill_done), VW'(m_done));
    check("busy", VW'(busy), VW'(m_active || m_done));
    if (busy) busy_cnt++;
    if (fill_done) done_cnt++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst        = 1'b0;
    we         = 1'b0;
    wa         = '0;
    wmask      = '0;
    wd         = '0;
    fill_start = 1'b0;
    fill_addr  = '0;
    fill_valid = 1'b0;
    fill_data  = '0;
  endtask

  localparam logic [LANE_W-1:0] LA = 32'hA0A0_0001;
  localparam logic [LANE_W-1:0] LB = 32'hB0B0_0002;
  localparam logic [LANE_W-1:0] LC = 32'hC0C0_0003;
  localparam logic [LANE_W-1:0] LD = 32'hD0D0_0004;

  initial begin
    idle_inputs();
    ra1 = '0;
    ra2 = '0;
    for (int r = 0; r < NREGS; r++) m_regs[r] = 'x;
    m_active = 0; m_done = 0; m_lane = 0; m_faddr = 0;
    @(negedge clk);

    // Reset, then model and DUT both clear.
    rst = 1'b1;
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      ra1 = AW'(r);
      ra2 = AW'(NREGS - 1 - r);
      cycle();
    end
    $display("[TB] reset read-back done");

    // Masked write to reg3 with same-cycle bypass on read port 1.
    ra1 = 3; ra2 = 3;
    we = 1'b1; wa = 3; wmask = 4'b0101; wd = {LD, LC, LB, LA};
    #1;
    check("bypass_rd1", rd1, {32'h0, LC, 32'h0, LA});
    cycle();
    idle_inputs();
    #1;
    check("masked_write", rd1, {32'h0, LC, 32'h0, LA});
    cycle();
    $display("[TB] masked write / bypass done");

    // Lane-serial fill of reg5 with a valid gap and a colliding port write.
    busy_cnt = 0;
    done_cnt = 0;
    ra1 = 5; ra2 = 3;
    fill_start = 1'b1; fill_addr = 5;
    cycle();
    idle_inputs();
    fill_valid = 1'b1; fill_data = 32'h11;
    cycle();
    fill_data = 32'h22;
    we = 1'b1; wa = 5; wmask = 4'b1111; wd = {LANES{32'hFF}};
    cycle();
    idle_inputs();
    fill_start = 1'b1; fill_addr = 2;   // ignored while filling
    cycle();
    fill_start = 1'b0;
    cycle();
    fill_valid = 1'b1; fill_data = 32'h33;
    cycle();
    fill_data = 32'h44;
    cycle();
    idle_inputs();
    fill_start = 1'b1; fill_addr = 1;   // ignored in DONE
    cycle();
    fill_start = 1'b0;
    cycle();
    cycle();
    // Lane 0 was overwritten by the full-mask port write; lane 1 kept the beat.
    #1;
    check("fill_reg5", rd1, {32'h44, 32'h33, 32'h22, 32'hFF});
    check("busy_cycles", VW'(busy_cnt), VW'(7));
    check("done_pulses", VW'(done_cnt), VW'(1));
    $display("[TB] fill of reg5 done");

    // Reset after two beats aborts the fill without a completion pulse.
    done_cnt = 0;
    ra1 = 6;
    fill_start = 1'b1; fill_addr = 6;
    cycle();
    idle_inputs();
    fill_valid = 1'b1; fill_data = 32'h5A;
    cycle();
    cycle();
    idle_inputs();
    rst = 1'b1;
    cycle();
    idle_inputs();
    for (int k = 0; k < 4; k++) cycle();
    check("abort_no_done", VW'(done_cnt), VW'(0));
    $display("[TB] reset mid-fill done");

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 79) == 0);
      ra1        = AW'($urandom);
      ra2        = AW'($urandom);
      we         = $urandom_range(0, 1) != 0;
      wa         = AW'($urandom);
      wmask      = LANES'($urandom);
      wd         = {$urandom, $urandom, $urandom, $urandom};
      fill_start = ($urandom_range(0, 3) == 0);
      fill_addr  = AW'($urandom);
      fill_valid = $urandom_range(0, 2) != 0;
      fill_data  = $urandom;
      if (($urandom_range(0, 3) == 0) && m_active) begin
        // Steer some port writes onto the lane currently being filled.
        we = 1'b1; wa = AW'(m_faddr); wmask = '1;
      end
      cycle();
    end
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
